// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the instruction fetch unit
package cpu_pkg;

   localparam int INST_WIDTH = 32;
   localparam logic [INST_WIDTH-1:0] INST_RESET_VALUE = 32'h0;

   typedef enum logic [1:0] {
      FETCH         = 2'd0,
      MISS_WAIT     = 2'd1,
      REDIRECT_WAIT = 2'd2
   } fetch_state_t;

   typedef enum logic [1:0] {
      PC_HOLD     = 2'd0,
      PC_INC      = 2'd1,
      PC_REDIRECT = 2'd2
   } pc_sel_t;

endpackage

// File: rtl/pc_next_gen.sv
// rtl/pc_next_gen.sv - combinational next fetch PC select: hold, +4 or redirect target
import cpu_pkg::*;

module pc_next_gen #(
   parameter int PC_WIDTH = 32
) (
   input  logic [1:0]          sel,
   input  logic [PC_WIDTH-1:0] pc,
   input  logic [PC_WIDTH-1:0] target,
   output logic [PC_WIDTH-1:0] next_pc
);

   // The +4 path wraps naturally modulo 2^PC_WIDTH
   always_comb begin
      next_pc = pc;
      case (sel)
         PC_INC:      next_pc = pc + PC_WIDTH'(4);
         PC_REDIRECT: next_pc = target;
         default:     next_pc = pc;
      endcase
   end

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - single-issue instruction fetch with miss/redirect handling; optional IFETCH_PERF_CNT_EN counters
import cpu_pkg::*;

module inst_fetch_unit #(
   parameter int                     PC_WIDTH    = 32,
   parameter int                     IADDR_WIDTH = 10,
   parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   cpu_stall,
   input  logic                   redirect,
   input  logic [PC_WIDTH-1:0]    redirect_target,
   output logic [IADDR_WIDTH-1:0] ic_address,
   input  logic                   ic_busywait,
   input  logic [INST_WIDTH-1:0]  ic_instruction,
   output logic [INST_WIDTH-1:0]  inst_out,
   output logic [PC_WIDTH-1:0]    pc_out,
   output logic [PC_WIDTH-1:0]    pc_plus4,
`ifdef IFETCH_PERF_CNT_EN
   output logic [31:0]            fetch_count,
   output logic [31:0]            miss_stall_cycles,
   output logic [31:0]            redirect_count,
`endif
   output logic                   inst_valid
);

   localparam logic [PC_WIDTH-1:0] ALIGN_MASK       = ~PC_WIDTH'(3);
   localparam logic [PC_WIDTH-1:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;

   fetch_state_t          state;
   logic [PC_WIDTH-1:0]   fetch_pc;
   logic [PC_WIDTH-1:0]   next_pc;
   logic                  redir_pending;
   logic [PC_WIDTH-1:0]   redir_target_q;

   logic                  redir_now;
   logic [PC_WIDTH-1:0]   redir_aligned;
   logic [PC_WIDTH-1:0]   redir_tgt;
   logic                  issue;
   logic                  load_redir;
   logic [1:0]            pc_sel;

   assign ic_address    = fetch_pc[IADDR_WIDTH-1:0];
   assign pc_plus4      = pc_out + PC_WIDTH'(4);
   assign redir_aligned = redirect_target & ALIGN_MASK;
   assign redir_now     = redirect | redir_pending;
   // A redirect seen this cycle overrides any latched one (last wins)
   assign redir_tgt     = redirect ? redir_aligned : redir_target_q;

   // Decide whether this cycle issues an instruction or jumps to a redirect target
   always_comb begin
      issue      = 1'b0;
      load_redir = 1'b0;
      pc_sel     = PC_HOLD;
      if (!cpu_stall) begin
         case (state)
            FETCH: begin
               if (redir_now)         load_redir = 1'b1;
               else if (!ic_busywait) issue      = 1'b1;
            end
            MISS_WAIT: begin
               if (!ic_busywait) begin
                  if (redir_now) load_redir = 1'b1;
                  else           issue      = 1'b1;
               end
            end
            REDIRECT_WAIT: begin
               if (!ic_busywait) load_redir = 1'b1;
            end
            default: ;
         endcase
      end
      if (load_redir)  pc_sel = PC_REDIRECT;
      else if (issue)  pc_sel = PC_INC;
   end

   pc_next_gen #(
      .PC_WIDTH (PC_WIDTH)
   ) u_pc_next_gen (
      .sel     (pc_sel),
      .pc      (fetch_pc),
      .target  (redir_tgt),
      .next_pc (next_pc)
   );

   // Fetch FSM, output registers and pending-redirect latch
   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= FETCH;
         fetch_pc       <= RESET_PC_ALIGNED;
         inst_out       <= INST_RESET_VALUE;
         pc_out         <= RESET_PC_ALIGNED;
         inst_valid     <= 1'b0;
         redir_pending  <= 1'b0;
         redir_target_q <= '0;
      end else begin
         fetch_pc <= next_pc;

         if (!cpu_stall) begin
            inst_valid <= issue;
            if (issue) begin
               inst_out <= ic_instruction;
               pc_out   <= fetch_pc;
            end
         end

         if (load_redir) begin
            redir_pending <= 1'b0;
         end else if (redirect) begin
            redir_pending  <= 1'b1;
            redir_target_q <= redir_aligned;
         end

         if (!cpu_stall) begin
            case (state)
               FETCH: begin
                  if (!redir_now && ic_busywait) state <= MISS_WAIT;
               end
               MISS_WAIT: begin
                  if (!ic_busywait)   state <= FETCH;
                  else if (redir_now) state <= REDIRECT_WAIT;
               end
               REDIRECT_WAIT: begin
                  if (!ic_busywait) state <= FETCH;
               end
               default: state <= FETCH;
            endcase
         end
      end
   end

`ifdef IFETCH_PERF_CNT_EN
   // Saturating event counters: issued instructions, cycles spent waiting on the cache, redirect requests
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_count       <= '0;
         miss_stall_cycles <= '0;
         redirect_count    <= '0;
      end else begin
         if (issue && fetch_count != 32'hFFFF_FFFF)
            fetch_count <= fetch_count + 32'd1;
         if (state != FETCH && miss_stall_cycles != 32'hFFFF_FFFF)
            miss_stall_cycles <= miss_stall_cycles + 32'd1;
         if (redirect && redirect_count != 32'hFFFF_FFFF)
            redirect_count <= redirect_count + 32'd1;
      end
   end
`endif

endmodule
